// File: rtl/dfi_closed_page_master.sv
// Closed-page DFI master for a 1:2 DDR PHY: every request runs ACT -> RD/WR -> PRE-all,
// with periodic auto-refresh inserted between requests.
module dfi_closed_page_master #(
   parameter int NUM_AD = 13,
   parameter int NUM_BA = 2,
   parameter int NUM_D  = 64,
   parameter int COL_W  = 10,
   parameter int TRCD   = 2,
   parameter int TWR    = 2,
   parameter int TRP    = 2,
   parameter int TRFC   = 10,
   parameter int TREFI  = 780
) (
   input  logic                            sys_clk,
   input  logic                            sys_rst_n,
   input  logic                            req_valid,
   output logic                            req_ready,
   input  logic                            req_we,
   input  logic [NUM_BA+NUM_AD+COL_W-1:0]  req_adr,
   input  logic [2*NUM_D-1:0]              req_wdata,
   input  logic [2*NUM_D/8-1:0]            req_wmask,
   output logic                            rsp_valid,
   output logic [2*NUM_D-1:0]              rsp_rdata,
   output logic                            busy,
   output logic [NUM_AD-1:0]               dfi_address_p0,
   output logic [NUM_AD-1:0]               dfi_address_p1,
   output logic [NUM_BA-1:0]               dfi_bank_p0,
   output logic [NUM_BA-1:0]               dfi_bank_p1,
   output logic                            dfi_cs_n_p0,
   output logic                            dfi_cs_n_p1,
   output logic                            dfi_cke_p0,
   output logic                            dfi_cke_p1,
   output logic                            dfi_ras_n_p0,
   output logic                            dfi_ras_n_p1,
   output logic                            dfi_cas_n_p0,
   output logic                            dfi_cas_n_p1,
   output logic                            dfi_we_n_p0,
   output logic                            dfi_we_n_p1,
   output logic                            dfi_wrdata_en_p0,
   output logic                            dfi_wrdata_en_p1,
   output logic [NUM_D/8-1:0]              dfi_wrdata_mask_p0,
   output logic [NUM_D/8-1:0]              dfi_wrdata_mask_p1,
   output logic [NUM_D-1:0]                dfi_wrdata_p0,
   output logic [NUM_D-1:0]                dfi_wrdata_p1,
   output logic                            dfi_rddata_en_p0,
   output logic                            dfi_rddata_en_p1,
   input  logic [NUM_D-1:0]                dfi_rddata_w0,
   input  logic [NUM_D-1:0]                dfi_rddata_w1,
   input  logic                            dfi_rddata_valid_w0
);

   localparam int MSK_W = NUM_D/8;
   localparam int T_AB  = (TRCD > TWR) ? TRCD : TWR;
   localparam int T_CD  = (TRP > TRFC) ? TRP : TRFC;
   localparam int TMAX  = (T_AB > T_CD) ? T_AB : T_CD;
   localparam int CNT_W = $clog2(TMAX) + 1;
   localparam int REF_W = $clog2(TREFI) + 1;
   localparam logic [NUM_AD-1:0] A10 = NUM_AD'(1) << 10;

   localparam logic [2:0] CMD_NOP = 3'b111;
   localparam logic [2:0] CMD_ACT = 3'b011;
   localparam logic [2:0] CMD_RD  = 3'b101;
   localparam logic [2:0] CMD_WR  = 3'b100;
   localparam logic [2:0] CMD_PRE = 3'b010;
   localparam logic [2:0] CMD_REF = 3'b001;

   typedef enum logic [3:0] {
      S_IDLE, S_TRCD_WAIT, S_CMD, S_RD_EN, S_RD_WAIT,
      S_WR_DATA, S_TWR_WAIT, S_PRE, S_TRP_WAIT, S_TRFC_WAIT
   } state_t;

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic [REF_W-1:0]     ref_cnt;
   logic                 ref_pending;
   logic                 issue_ref;
   logic                 rsp_hold;

   logic                 lat_we;
   logic [NUM_BA-1:0]    lat_bank;
   logic [COL_W-1:0]     lat_col;
   logic [2*NUM_D-1:0]   lat_wdata;
   logic [2*MSK_W-1:0]   lat_wmask;
   logic [NUM_AD-1:0]    col_addr;
   logic [NUM_AD-1:0]    req_row;
   logic [NUM_BA-1:0]    req_bank;

   assign req_row   = req_adr[COL_W +: NUM_AD];
   assign req_bank  = req_adr[COL_W+NUM_AD +: NUM_BA];
   // Column goes on the low address lines; A10 must stay low so RD/WR never auto-precharge.
   assign col_addr  = NUM_AD'(lat_col) & ~A10;
   assign busy      = (state != S_IDLE);
   assign req_ready = req_valid && dfi_cke_p0 && (state == S_IDLE) && !ref_pending;
   assign issue_ref = (state == S_IDLE) && ref_pending;

   always_ff @(posedge sys_clk) begin
      if (req_ready) begin
         lat_we    <= req_we;
         lat_bank  <= req_bank;
         lat_col   <= req_adr[COL_W-1:0];
         lat_wdata <= req_wdata;
         lat_wmask <= req_wmask;
      end
   end

   // Expiry while a refresh is still pending just re-arms the flag; refreshes are not queued.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         ref_cnt     <= REF_W'(TREFI - 1);
         ref_pending <= 1'b0;
      end else begin
         if (issue_ref)
            ref_pending <= 1'b0;
         if (ref_cnt == '0) begin
            ref_cnt     <= REF_W'(TREFI - 1);
            ref_pending <= 1'b1;
         end else begin
            ref_cnt <= ref_cnt - 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state              <= S_IDLE;
         cnt                <= '0;
         rsp_hold           <= 1'b0;
         rsp_valid          <= 1'b0;
         rsp_rdata          <= '0;
         dfi_cke_p0         <= 1'b0;
         dfi_cke_p1         <= 1'b0;
         dfi_cs_n_p0        <= 1'b1;
         dfi_cs_n_p1        <= 1'b1;
         {dfi_ras_n_p0, dfi_cas_n_p0, dfi_we_n_p0} <= CMD_NOP;
         {dfi_ras_n_p1, dfi_cas_n_p1, dfi_we_n_p1} <= CMD_NOP;
         dfi_address_p0     <= '0;
         dfi_address_p1     <= '0;
         dfi_bank_p0        <= '0;
         dfi_bank_p1        <= '0;
         dfi_wrdata_en_p0   <= 1'b0;
         dfi_wrdata_en_p1   <= 1'b0;
         dfi_wrdata_mask_p0 <= '0;
         dfi_wrdata_mask_p1 <= '0;
         dfi_wrdata_p0      <= '0;
         dfi_wrdata_p1      <= '0;
         dfi_rddata_en_p0   <= 1'b0;
         dfi_rddata_en_p1   <= 1'b0;
      end else begin
         // Both phases default to a selected NOP; only the commanding state overrides one phase.
         dfi_cke_p0         <= 1'b1;
         dfi_cke_p1         <= 1'b1;
         dfi_cs_n_p0        <= 1'b0;
         dfi_cs_n_p1        <= 1'b0;
         {dfi_ras_n_p0, dfi_cas_n_p0, dfi_we_n_p0} <= CMD_NOP;
         {dfi_ras_n_p1, dfi_cas_n_p1, dfi_we_n_p1} <= CMD_NOP;
         dfi_address_p0     <= '0;
         dfi_address_p1     <= '0;
         dfi_bank_p0        <= '0;
         dfi_bank_p1        <= '0;
         dfi_wrdata_en_p0   <= 1'b0;
         dfi_wrdata_en_p1   <= 1'b0;
         dfi_wrdata_mask_p0 <= '0;
         dfi_wrdata_mask_p1 <= '0;
         dfi_wrdata_p0      <= '0;
         dfi_wrdata_p1      <= '0;
         dfi_rddata_en_p0   <= 1'b0;
         dfi_rddata_en_p1   <= 1'b0;
         rsp_hold           <= 1'b0;
         rsp_valid          <= rsp_hold;

         // Wait states last T-1 cycles so the next command lands exactly T cycles after the last.
         case (state)
            S_IDLE: begin
               if (ref_pending) begin
                  {dfi_ras_n_p0, dfi_cas_n_p0, dfi_we_n_p0} <= CMD_REF;
                  if (TRFC > 1) begin
                     state <= S_TRFC_WAIT;
                     cnt   <= CNT_W'(TRFC - 2);
                  end
               end else if (req_ready) begin
                  {dfi_ras_n_p0, dfi_cas_n_p0, dfi_we_n_p0} <= CMD_ACT;
                  dfi_address_p0 <= req_row;
                  dfi_bank_p0    <= req_bank;
                  if (TRCD > 1) begin
                     state <= S_TRCD_WAIT;
                     cnt   <= CNT_W'(TRCD - 2);
                  end else begin
                     state <= S_CMD;
                  end
               end
            end
            S_TRCD_WAIT: begin
               if (cnt == '0) state <= S_CMD;
               else           cnt   <= cnt - 1'b1;
            end
            S_CMD: begin
               if (!lat_we) begin
                  {dfi_ras_n_p0, dfi_cas_n_p0, dfi_we_n_p0} <= CMD_RD;
                  dfi_address_p0 <= col_addr;
                  dfi_bank_p0    <= lat_bank;
                  state          <= S_RD_EN;
               end else begin
                  {dfi_ras_n_p1, dfi_cas_n_p1, dfi_we_n_p1} <= CMD_WR;
                  dfi_address_p1 <= col_addr;
                  dfi_bank_p1    <= lat_bank;
                  state          <= S_WR_DATA;
               end
            end
            S_RD_EN: begin
               dfi_rddata_en_p0 <= 1'b1;
               dfi_rddata_en_p1 <= 1'b1;
               state            <= S_RD_WAIT;
            end
            S_RD_WAIT: begin
               if (dfi_rddata_valid_w0) begin
                  rsp_rdata <= {dfi_rddata_w1, dfi_rddata_w0};
                  rsp_hold  <= 1'b1;
                  state     <= S_PRE;
               end
            end
            S_WR_DATA: begin
               dfi_wrdata_en_p0   <= 1'b1;
               dfi_wrdata_en_p1   <= 1'b1;
               dfi_wrdata_p0      <= lat_wdata[NUM_D-1:0];
               dfi_wrdata_p1      <= lat_wdata[2*NUM_D-1:NUM_D];
               dfi_wrdata_mask_p0 <= ~lat_wmask[MSK_W-1:0];
               dfi_wrdata_mask_p1 <= ~lat_wmask[2*MSK_W-1:MSK_W];
               if (TWR > 1) begin
                  state <= S_TWR_WAIT;
                  cnt   <= CNT_W'(TWR - 2);
               end else begin
                  state <= S_PRE;
               end
            end
            S_TWR_WAIT: begin
               if (cnt == '0) state <= S_PRE;
               else           cnt   <= cnt - 1'b1;
            end
            S_PRE: begin
               {dfi_ras_n_p0, dfi_cas_n_p0, dfi_we_n_p0} <= CMD_PRE;
               dfi_address_p0 <= A10;
               if (TRP > 1) begin
                  state <= S_TRP_WAIT;
                  cnt   <= CNT_W'(TRP - 2);
               end else begin
                  state <= S_IDLE;
               end
            end
            S_TRP_WAIT, S_TRFC_WAIT: begin
               if (cnt == '0) state <= S_IDLE;
               else           cnt   <= cnt - 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
